idma_nd_rsp_tagger: RTL

- Sits between the ND midend's 1D burst request/response interface and the 1D backend. It is the responder-side counterpart of the midend.
- Forwards each 1D burst request to the backend and records the request's opt.last flag in an in-order tag FIFO.
- Marks each backend response with rsp.last taken from that FIFO.
- Accumulates errors across all bursts of one ND transfer, so the single response the midend forwards carries any intermediate error.

---
 rtl/idma_nd_rsp_tagger.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/idma_nd_rsp_tagger.sv
// idma_nd_rsp_tagger
//   Responder-side companion of the ND midend. 1D burst requests are passed
//   straight through to the backend. The opt.last flag of each accepted request
//   is stored in an in-order tag FIFO. Each backend response leaves with its
//   rsp.last set from the head of that FIFO. Errors from the intermediate
//   bursts of an ND transfer are collected and folded into that transfer's
//   final (last = 1) response. This means the one response the midend forwards
//   still reports any earlier failure.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i/valid/ready   1D burst request from the midend
//   be_req_o/valid/rdy  request forwarded to the backend
//   be_rsp_i/valid/rdy  backend response, one per request, in order
//   rsp_o/valid/ready   tagged response to the midend
//   outstanding_o       bursts accepted but not yet answered
//   busy_o              bursts in flight or an error pending for the transfer

package idma_nd_rsp_tagger_pkg;

  typedef struct packed {
    logic last;
  } opt_t;

  typedef struct packed {
    logic [31:0] length;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    opt_t        opt;
  } req_t;

  typedef struct packed {
    logic        last;
    logic        error;
    logic [31:0] pld;
  } rsp_t;

endpackage

module idma_nd_rsp_tagger #(
  parameter int unsigned NumOutstanding = 8,
  parameter type idma_req_t = idma_nd_rsp_tagger_pkg::req_t,
  parameter type idma_rsp_t = idma_nd_rsp_tagger_pkg::rsp_t,
  localparam int unsigned CntW = $clog2(NumOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  idma_req_t       req_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  output idma_req_t       be_req_o,
  output logic            be_req_valid_o,
  input  logic            be_req_ready_i,
  input  idma_rsp_t       be_rsp_i,
  input  logic            be_rsp_valid_i,
  output logic            be_rsp_ready_o,
  output idma_rsp_t       rsp_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            busy_o
);

  localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned PldW = $bits(be_rsp_i.pld);

  logic [NumOutstanding-1:0] tag_q;
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           count_q;
  logic                      err_q;
  logic [PldW-1:0]           err_pld_q;

  logic full, empty, push, pop, head;

  // Pointers wrap explicitly so that a depth that is not a power of two works.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(NumOutstanding - 1)) return '0;
    else return p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(NumOutstanding));
  assign empty = (count_q == '0);
  assign head  = tag_q[rd_ptr_q];

  // A pop does not free a slot for a push in the same cycle. This keeps
  // req_ready_o off the response-path timing.
  assign be_req_o       = req_i;
  assign be_req_valid_o = req_valid_i & ~full;
  assign req_ready_o    = be_req_ready_i & ~full;
  assign push           = be_req_valid_o & be_req_ready_i;

  // There is no fall-through: a tag has to be stored before its response
  // can leave.
  assign rsp_valid_o    = be_rsp_valid_i & ~empty;
  assign be_rsp_ready_o = rsp_ready_i & ~empty;
  assign pop            = rsp_valid_o & rsp_ready_i;

  assign outstanding_o  = count_q;
  assign busy_o         = ~empty | err_q;

  // The final response of a transfer carries every earlier error. Its payload
  // is the payload of the first error seen.
  always_comb begin
    rsp_o      = be_rsp_i;
    rsp_o.last = head;
    if (head) begin
      rsp_o.error = be_rsp_i.error | err_q;
      if (err_q) rsp_o.pld = err_pld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      err_pld_q <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= req_i.opt.last;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);

      if (pop) begin
        if (head) begin
          err_q     <= 1'b0;
          err_pld_q <= '0;
        end else if (be_rsp_i.error && !err_q) begin
          err_q     <= 1'b1;
          err_pld_q <= be_rsp_i.pld;
        end
      end
    end
  end

  // A backend response with no request outstanding has no tag to pair with.
  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(be_rsp_valid_i && empty));

endmodule
